vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for VGA-style displays. A clock divider produces
//   one pixel tick every DIV enabled clk cycles; a horizontal counter walks
//   the line (display, front porch, sync, back porch) and a vertical counter
//   walks the frame the same way. Every output is registered from the
//   counter state, so all outputs move together exactly one clk after the
//   state they describe.
//
// Parameters:
//   HD, HF, HR, HB : horizontal display / front porch / sync / back porch
//   VD, VF, VR, VB : vertical display / front porch / sync / back porch
//   DIV            : clk cycles per pixel (>= 1)
//   HS_POL, VS_POL : sync active level (0 = active-low)
//   CW             : coordinate width, must hold HT-1 and VT-1
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   en           in   count enable; low freezes the timing position
//   p_tick       out  high in the last clk cycle of each presented pixel
//   hsync        out  horizontal sync at HS_POL when active
//   vsync        out  vertical sync at VS_POL when active
//   visible      out  presented pixel lies inside HD x VD
//   pixel_x      out  presented horizontal position
//   pixel_y      out  presented vertical position
//   line_start   out  one-cycle pulse when a line begins (h == 0)
//   frame_start  out  one-cycle pulse when a frame begins (h == 0, v == 0)
//   vblank_start out  one-cycle pulse when vertical blanking begins (v == VD)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int HD     = 640,
  parameter int HF     = 16,
  parameter int HR     = 96,
  parameter int HB     = 48,
  parameter int VD     = 480,
  parameter int VF     = 10,
  parameter int VR     = 2,
  parameter int VB     = 33,
  parameter int DIV    = 2,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);

  // -------------------------------------------------------------------------
  // Derived geometry
  // -------------------------------------------------------------------------
  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;

  // A one-bit divider is kept even for DIV=1 so the register never has
  // zero width; it simply stays at 0 in that case.
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [CW-1:0] H_DISP = CW'(HD);
  localparam logic [CW-1:0] V_DISP = CW'(VD);
  localparam logic [CW-1:0] HS_BEG = CW'(HD + HF);
  localparam logic [CW-1:0] HS_END = CW'(HD + HF + HR - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(VD + VF);
  localparam logic [CW-1:0] VS_END = CW'(VD + VF + VR - 1);

  // -------------------------------------------------------------------------
  // Timing state
  // -------------------------------------------------------------------------
  logic [DW-1:0] div;
  logic [CW-1:0] h;
  logic [CW-1:0] v;

  // "entered" marks that the current (h, v) position has just been reached,
  // either by leaving reset or by a pixel tick. Gating the start pulses with
  // it keeps them to one cycle even when en holds the position still.
  logic          entered;

  logic          tick;

  assign tick = en && (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div     <= '0;
      h       <= '0;
      v       <= '0;
      entered <= 1'b1;
    end else begin
      entered <= tick;

      if (en) begin
        if (div == DIV_LAST) begin
          div <= '0;
        end else begin
          div <= div + DW'(1);
        end
      end

      if (tick) begin
        if (h == H_LAST) begin
          h <= '0;
          if (v == V_LAST) begin
            v <= '0;
          end else begin
            v <= v + CW'(1);
          end
        end else begin
          h <= h + CW'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the counter state (registered below)
  // -------------------------------------------------------------------------
  logic hs_act;
  logic vs_act;
  logic vis_nxt;
  logic line_nxt;
  logic frame_nxt;
  logic vblank_nxt;

  always_comb begin
    hs_act     = (h >= HS_BEG) && (h <= HS_END);
    vs_act     = (v >= VS_BEG) && (v <= VS_END);
    vis_nxt    = (h < H_DISP) && (v < V_DISP);
    line_nxt   = entered && (h == '0);
    frame_nxt  = line_nxt && (v == '0);
    vblank_nxt = line_nxt && (v == V_DISP);
  end

  // All outputs share one register stage so they stay mutually aligned.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_tick       <= 1'b0;
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      visible      <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      p_tick       <= tick;
      hsync        <= hs_act ? HS_POL : ~HS_POL;
      vsync        <= vs_act ? VS_POL : ~VS_POL;
      visible      <= vis_nxt;
      pixel_x      <= h;
      pixel_y      <= v;
      line_start   <= line_nxt;
      frame_start  <= frame_nxt;
      vblank_start <= vblank_nxt;
    end
  end

endmodule
